// File: rtl/gemv_pkg.sv
// Shared definitions for the GEMV row controller.
// Holds the controller state encoding, the default array geometry
// (N columns per row, M rows per job, DW element width) and a helper
// that sizes row-index ports so that a single-row job still gets a
// one-bit index.
package gemv_pkg;

    localparam int GEMV_N  = 786;
    localparam int GEMV_M  = 64;
    localparam int GEMV_DW = 16;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_GO   = 3'd2,
        ST_WAIT = 3'd3,
        ST_OUT  = 3'd4,
        ST_FIN  = 3'd5
    } state_t;

    // Width of a row index for a job of 'depth' rows (never below 1 bit).
    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/gemv_timeout.sv
// PE watchdog counter.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : restart the count from zero (new PE operation)
//   enable     : count this cycle (PE result outstanding)
//   limit      : number of enabled cycles allowed before expiry
//   expired    : high in the last allowed cycle while enabled, so the
//                owner reacts on the edge that completes 'limit' cycles
module gemv_timeout #(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          enable,
    input  logic [CW-1:0] limit,
    output logic          expired
);

    logic [CW-1:0] count_r;

    // Cycle counter: zeroed on clear, advances while enabled, saturates at limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= '0;
        end else if (clear) begin
            count_r <= '0;
        end else if (enable && (count_r != limit)) begin
            count_r <= count_r + 1'b1;
        end
    end

    assign expired = enable && (count_r >= (limit - 1'b1));

endmodule

// File: rtl/gemv_ctrl.sv
// GEMV row-sequencing controller.
// Walks rows 0..M-1 of a job: requests a row buffer load, pulses the PE,
// waits for its dot product (guarded by a watchdog), and hands the result
// to a valid/ready consumer before moving on. Rows are strictly sequential.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   start, abort        : begin job (IDLE only) / cancel job (abort wins)
//   busy, done, err     : job in progress, completion pulse, sticky timeout
//   row_req/row_addr    : row load request and row index; row_ack completes it
//   pe_valid            : one-cycle PE start; pe_done/pe_y return the result
//   y_valid/y_ready     : result handshake carrying y_data and its row y_idx
// All outputs are registered.
module gemv_ctrl
    import gemv_pkg::*;
#(
    parameter int N  = GEMV_N,
    parameter int M  = GEMV_M,
    parameter int DW = GEMV_DW,
    parameter int TO = N + 8
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    input  logic                              abort,
    output logic                              busy,
    output logic                              done,
    output logic                              err,
    output logic                              row_req,
    output logic [idx_width(M)-1:0]           row_addr,
    input  logic                              row_ack,
    output logic                              pe_valid,
    input  logic                              pe_done,
    input  logic signed [2*DW-1:0]            pe_y,
    output logic                              y_valid,
    input  logic                              y_ready,
    output logic signed [2*DW-1:0]            y_data,
    output logic [idx_width(M)-1:0]           y_idx
);

    localparam int AW = idx_width(M);
    localparam int CW = $clog2(TO + 1);
    localparam logic [AW-1:0] LAST_ROW = AW'(M - 1);
    localparam logic [CW-1:0] TO_LIMIT = CW'(TO);

    state_t                 state_r;
    state_t                 state_s;
    logic [AW-1:0]          r_r;
    logic [AW-1:0]          r_s;
    logic                   err_s;
    logic signed [2*DW-1:0] y_data_s;
    logic [AW-1:0]          y_idx_s;
    logic                   to_clear_s;
    logic                   to_en_s;
    logic                   to_expired_s;

    // The watchdog restarts while the PE is launched and runs while its result is awaited.
    assign to_clear_s = (state_r == ST_GO);
    assign to_en_s    = (state_r == ST_WAIT);

    gemv_timeout #(
        .CW(CW)
    ) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (to_clear_s),
        .enable  (to_en_s),
        .limit   (TO_LIMIT),
        .expired (to_expired_s)
    );

    // Next-state, row counter, sticky error and result capture.
    always_comb begin
        state_s  = state_r;
        r_s      = r_r;
        err_s    = err;
        y_data_s = y_data;
        y_idx_s  = y_idx;
        case (state_r)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_s = ST_LOAD;
                    r_s     = '0;
                    err_s   = 1'b0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (abort) begin
                    state_s = ST_IDLE;
                end else if (row_ack) begin
                    state_s = ST_GO;
                end else begin
                    state_s = ST_LOAD;
                end
            end
            ST_GO: begin
                // pe_done is deliberately not looked at here: it still
                // reflects the previous row until the PE sees pe_valid.
                if (abort) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (abort) begin
                    state_s = ST_IDLE;
                end else if (pe_done) begin
                    state_s  = ST_OUT;
                    y_data_s = pe_y;
                    y_idx_s  = r_r;
                end else if (to_expired_s) begin
                    state_s = ST_IDLE;
                    err_s   = 1'b1;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_OUT: begin
                if (abort) begin
                    state_s = ST_IDLE;
                end else if (y_ready) begin
                    if (r_r == LAST_ROW) begin
                        state_s = ST_FIN;
                    end else begin
                        state_s = ST_LOAD;
                        r_s     = r_r + 1'b1;
                    end
                end else begin
                    state_s = ST_OUT;
                end
            end
            ST_FIN: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; each strobe is decoded from the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            r_r      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            row_req  <= 1'b0;
            row_addr <= '0;
            pe_valid <= 1'b0;
            y_valid  <= 1'b0;
            y_data   <= '0;
            y_idx    <= '0;
        end else begin
            state_r  <= state_s;
            r_r      <= r_s;
            busy     <= (state_s != ST_IDLE);
            done     <= (state_s == ST_FIN);
            err      <= err_s;
            row_req  <= (state_s == ST_LOAD);
            row_addr <= r_s;
            pe_valid <= (state_s == ST_GO);
            y_valid  <= (state_s == ST_OUT);
            y_data   <= y_data_s;
            y_idx    <= y_idx_s;
        end
    end

endmodule
